// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: op codes, reset/stall levels and
// helpers for classifying accesses and building store byte lanes.
package mem_stage_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  localparam logic [5:0] Lb  = 6'h20;
  localparam logic [5:0] Lh  = 6'h21;
  localparam logic [5:0] Lw  = 6'h23;
  localparam logic [5:0] Lbu = 6'h24;
  localparam logic [5:0] Lhu = 6'h25;
  localparam logic [5:0] Sb  = 6'h28;
  localparam logic [5:0] Sh  = 6'h29;
  localparam logic [5:0] Sw  = 6'h2b;

  function automatic logic is_load(input logic [5:0] op);
    return (op == Lb) || (op == Lbu) || (op == Lh) || (op == Lhu) || (op == Lw);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == Sb) || (op == Sh) || (op == Sw);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] k);
    case (op)
      Lw, Sw:       return k != 2'b00;
      Lh, Lhu, Sh:  return k[0];
      default:      return 1'b0;
    endcase
  endfunction

  // Loads always fetch the whole word; lane selection happens on return.
  function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] k);
    case (op)
      Sb:      return 4'b0001 << k;
      Sh:      return k[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] d);
    case (op)
      Sb:      return {4{d[7:0]}};
      Sh:      return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a returned word and extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  k_i,
  input  logic [5:0]  op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(rdata_i >> {k_i, 3'b000});
    half_sel = k_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (op_i)
      Lb:      data_o = {{24{byte_sel[7]}}, byte_sel};
      Lbu:     data_o = {24'h0, byte_sel};
      Lh:      data_o = {{16{half_sel[15]}}, half_sel};
      Lhu:     data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through, and runs loads/stores as a
// request/ack handshake to data memory while holding the pipeline.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [31:0] inst_i,
  input  logic [31:0] regcData_i,
  input  logic        regcWrite_i,
  input  logic [4:0]  regcAddr_i,
  input  logic [5:0]  op_i,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] memData_i,
  output logic [31:0] inst_o,
  output logic [31:0] regcData_o,
  output logic        regcWrite_o,
  output logic [4:0]  regcAddr_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stallreq_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e      state_q;
  logic [31:0] rdata_q;
  logic [5:0]  op_q;
  logic [1:0]  k_q;

  logic [1:0]  k;
  logic        is_mem, mis, issue;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  assign k       = memAddr_i[1:0];
  assign is_mem  = is_load(op_i) || is_store(op_i);
  assign mis     = is_mem && is_misaligned(op_i, k);
  assign issue   = (state_q == IDLE) && is_mem && !mis;
  assign be_d    = store_be(op_i, k);
  assign wdata_d = store_data(op_i, memData_i);

  // Op and lane are latched at issue so DONE does not depend on EX_MEM holding.
  mem_load_align u_align (
    .rdata_i (rdata_q),
    .k_i     (k_q),
    .op_i    (op_q),
    .data_o  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= ZeroWord;
      mem_wdata <= ZeroWord;
      mem_be    <= 4'b0000;
      rdata_q   <= ZeroWord;
      op_q      <= 6'h00;
      k_q       <= 2'b00;
    end else begin
      case (state_q)
        IDLE: if (issue) begin
          mem_req   <= 1'b1;
          mem_we    <= is_store(op_i);
          mem_addr  <= {memAddr_i[31:2], 2'b00};
          mem_be    <= be_d;
          mem_wdata <= wdata_d;
          op_q      <= op_i;
          k_q       <= k;
          state_q   <= REQ;
        end
        REQ: if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          rdata_q <= mem_rdata;
          state_q <= DONE;
        end
        DONE: if (!stall[4]) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    inst_o      = inst_i;
    regcAddr_o  = regcAddr_i;
    regcData_o  = regcData_i;
    regcWrite_o = regcWrite_i;
    stallreq_o  = NoStop;
    misalign_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mis) begin
          misalign_o  = 1'b1;
          regcWrite_o = 1'b0;
        end else if (issue) begin
          stallreq_o = Stop;
        end
      end
      REQ:  stallreq_o = Stop;
      DONE: begin
        if (is_load(op_q))  regcData_o  = load_data;
        if (is_store(op_q)) regcWrite_o = 1'b0;
      end
      default: ;
    endcase
    if (rst == RstEnable) begin
      stallreq_o = NoStop;
      misalign_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [5:0] OP_ADD = 6'h01;

  logic        clk, rst;
  logic [5:0]  stall;
  logic [31:0] inst_i, regcData_i, memAddr_i, memData_i, mem_rdata;
  logic        regcWrite_i, mem_ack;
  logic [4:0]  regcAddr_i;
  logic [5:0]  op_i;
  logic [31:0] inst_o, regcData_o, mem_addr, mem_wdata;
  logic        regcWrite_o, mem_req, mem_we, stallreq_o, misalign_o;
  logic [4:0]  regcAddr_o;
  logic [3:0]  mem_be;

  int checks, fails;
  logic chk_en;

  mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .inst_i(inst_i), .regcData_i(regcData_i),
    .regcWrite_i(regcWrite_i), .regcAddr_i(regcAddr_i), .op_i(op_i),
    .memAddr_i(memAddr_i), .memData_i(memData_i), .inst_o(inst_o),
    .regcData_o(regcData_o), .regcWrite_o(regcWrite_o), .regcAddr_o(regcAddr_o),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stallreq_o(stallreq_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (access-level view) ----------------
  function automatic bit m_is_ld(input logic [5:0] op);
    return op inside {Lb, Lbu, Lh, Lhu, Lw};
  endfunction
  function automatic bit m_is_st(input logic [5:0] op);
    return op inside {Sb, Sh, Sw};
  endfunction
  function automatic bit m_mis(input logic [5:0] op, input logic [31:0] a);
    if (op == Lw || op == Sw) return (a % 32'd4) != 0;
    if (op == Lh || op == Lhu || op == Sh) return (a % 32'd2) != 0;
    return 1'b0;
  endfunction
  function automatic logic [31:0] m_ld(input logic [31:0] w, input int k, input logic [5:0] op);
    int v;
    if (op == Lb || op == Lbu) begin
      v = int'((w >> (8 * k)) & 32'd255);
      if (op == Lb && v >= 128) v = v - 256;
    end else if (op == Lh || op == Lhu) begin
      v = int'((w >> (16 * (k / 2))) & 32'd65535);
      if (op == Lh && v >= 32768) v = v - 65536;
    end else return w;
    return 32'(v);
  endfunction
  function automatic logic [3:0] m_be(input logic [5:0] op, input int k);
    if (op == Sb) return 4'(1 << k);
    if (op == Sh) return (k == 0) ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction
  function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] d);
    if (op == Sb) return (d & 32'd255) * 32'h0101_0101;
    if (op == Sh) return (d & 32'd65535) * 32'h0001_0001;
    return d;
  endfunction

  int          ph;  // 0 waiting for an access, 1 request outstanding, 2 completed
  logic [5:0]  m_op;
  int          m_k;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_bev;
  logic        m_we;

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; m_rdata = 0;
    end else if (ph == 0) begin
      if ((m_is_ld(op_i) || m_is_st(op_i)) && !m_mis(op_i, memAddr_i)) begin
        ph = 1; m_op = op_i; m_k = int'(memAddr_i % 32'd4);
        m_addr = memAddr_i - memAddr_i % 32'd4;
        m_we = m_is_st(op_i); m_bev = m_be(op_i, m_k); m_wdata = m_wd(op_i, memData_i);
      end
    end else if (ph == 1) begin
      if (mem_ack) begin ph = 2; m_rdata = mem_rdata; end
    end else begin
      if (!stall[4]) ph = 0;
    end
  end

  int   req_rises;
  logic req_prev;
  initial begin req_rises = 0; req_prev = 1'b0; end

  always @(negedge clk) begin
    logic mm, memop;
    logic [31:0] ed;
    logic ew;
    if (mem_req === 1'b1 && !req_prev) req_rises++;
    req_prev = (mem_req === 1'b1);
    if (chk_en) begin
      memop = m_is_ld(op_i) || m_is_st(op_i);
      mm = m_mis(op_i, memAddr_i);
      ed = (ph == 2 && m_is_ld(m_op)) ? m_ld(m_rdata, m_k, m_op) : regcData_i;
      ew = ((ph == 0 && mm) || (ph == 2 && m_is_st(m_op))) ? 1'b0 : regcWrite_i;
      chk("stallreq", 32'(stallreq_o), 32'(!rst && (ph == 1 || (ph == 0 && memop && !mm))));
      chk("misalign", 32'(misalign_o), 32'(!rst && ph == 0 && mm));
      chk("mem_req", 32'(mem_req), 32'(ph == 1));
      chk("regcData", regcData_o, ed);
      chk("regcWrite", 32'(regcWrite_o), 32'(ew));
      chk("inst", inst_o, inst_i);
      chk("regcAddr", 32'(regcAddr_o), 32'(regcAddr_i));
      if (ph == 1) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_be", 32'(mem_be), 32'(m_bev));
        chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic mem_txn(input logic [5:0] op, input logic [31:0] addr, wdat, rdat,
                         input int ack_wait, input int hold,
                         output int ns, output logic [31:0] dout, output logic dwe,
                         output logic [31:0] oaddr, output logic [3:0] obe,
                         output logic [31:0] owd, output logic owe);
    op_i = op; memAddr_i = addr; memData_i = wdat; mem_rdata = rdat;
    regcWrite_i = 1'b1; regcData_i = 32'h5555_AAAA; ns = 0;
    #3 if (stallreq_o) ns++;
    tick;
    for (int c = 0; c <= ack_wait; c++) begin
      if (c == ack_wait) mem_ack = 1'b1;
      #3 if (stallreq_o) ns++;
      if (c == 0) begin oaddr = mem_addr; obe = mem_be; owd = mem_wdata; owe = mem_we; end
      tick;
    end
    mem_ack = 1'b0;
    stall = (hold > 0) ? 6'b010000 : 6'b000000;
    #3 if (stallreq_o) ns++;
    dout = regcData_o; dwe = regcWrite_o;
    for (int c = 0; c < hold; c++) tick;
    stall = 6'b000000;
    op_i = OP_ADD; memAddr_i = 32'h0;
    tick;
  endtask

  int          ns, r0;
  logic [31:0] d, a, wd;
  logic        w, we;
  logic [3:0]  be;

  initial begin
    checks = 0; fails = 0; chk_en = 1'b0;
    rst = 1'b1; stall = 6'b0; inst_i = 32'h1111_0000; regcData_i = 32'h0;
    regcWrite_i = 1'b0; regcAddr_i = 5'd0; op_i = Lw; memAddr_i = 32'h6;
    memData_i = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    tick; chk_en = 1'b1;
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_misalign", 32'(misalign_o), 32'h0);
    chk("rst_stallreq", 32'(stallreq_o), 32'h0);

    tick;
    rst = 1'b0; op_i = OP_ADD; memAddr_i = 32'h0; inst_i = 32'hDEAD_BEEF;
    regcData_i = 32'h1234; regcWrite_i = 1'b1; regcAddr_i = 5'd7; mem_ack = 1'b1;
    #3;
    chk("add_data", regcData_o, 32'h1234);
    chk("add_write", 32'(regcWrite_o), 32'h1);
    chk("add_stallreq", 32'(stallreq_o), 32'h0);
    chk("add_inst", inst_o, 32'hDEAD_BEEF);
    tick; mem_ack = 1'b0;
    tick;

    mem_txn(Lb, 32'h103, 32'h0, 32'h80FF_FFFF, 1, 0, ns, d, w, a, be, wd, we);
    chk("lb_addr", a, 32'h100);
    chk("lb_stall_cycles", 32'(ns), 32'd3);
    chk("lb_data", d, 32'hFFFF_FF80);
    chk("lb_be", 32'(be), 32'hF);
    chk("lb_we", 32'(we), 32'h0);
    mem_txn(Lbu, 32'h103, 32'h0, 32'h80FF_FFFF, 1, 0, ns, d, w, a, be, wd, we);
    chk("lbu_data", d, 32'h0000_0080);

    mem_txn(Sh, 32'h202, 32'hABCD, 32'h0, 0, 0, ns, d, w, a, be, wd, we);
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", wd, 32'hABCD_ABCD);
    chk("sh_we", 32'(we), 32'h1);
    chk("sh_done_write", 32'(w), 32'h0);
    chk("sh_addr", a, 32'h200);

    op_i = Lw; memAddr_i = 32'h6; regcWrite_i = 1'b1;
    #3;
    chk("mis_flag", 32'(misalign_o), 32'h1);
    chk("mis_write", 32'(regcWrite_o), 32'h0);
    chk("mis_stallreq", 32'(stallreq_o), 32'h0);
    tick;
    #3 chk("mis_req", 32'(mem_req), 32'h0);
    op_i = OP_ADD; memAddr_i = 32'h0;
    tick;

    r0 = req_rises;
    mem_txn(Sw, 32'h40, 32'hCAFE_F00D, 32'h0, 0, 2, ns, d, w, a, be, wd, we);
    chk("sw_one_txn", 32'(req_rises - r0), 32'd1);
    chk("sw_wdata", wd, 32'hCAFE_F00D);
    chk("sw_be", 32'(be), 32'hF);

    mem_txn(Lh, 32'h2, 32'h0, 32'h8001_7FFF, 0, 0, ns, d, w, a, be, wd, we);
    chk("lh_data", d, 32'hFFFF_8001);
    mem_txn(Lhu, 32'h2, 32'h0, 32'h8001_7FFF, 0, 0, ns, d, w, a, be, wd, we);
    chk("lhu_data", d, 32'h0000_8001);
    mem_txn(Sb, 32'h11, 32'h5A, 32'h0, 0, 0, ns, d, w, a, be, wd, we);
    chk("sb_be", 32'(be), 32'h2);
    chk("sb_wdata", wd, 32'h5A5A_5A5A);
    mem_txn(Lw, 32'h8, 32'h0, 32'h1234_5678, 0, 0, ns, d, w, a, be, wd, we);
    chk("lw_data", d, 32'h1234_5678);
    chk("lw_min_stall", 32'(ns), 32'd2);

    op_i = Lw; memAddr_i = 32'h40; regcData_i = 32'h5555_AAAA; mem_rdata = 32'hFFFF_0000;
    tick;
    tick; rst = 1'b1;
    #3 chk("rr_stallreq_in_rst", 32'(stallreq_o), 32'h0);
    tick;
    rst = 1'b0; op_i = OP_ADD; memAddr_i = 32'h0; regcData_i = 32'h77; mem_ack = 1'b1;
    #3;
    chk("rr_req", 32'(mem_req), 32'h0);
    chk("rr_data", regcData_o, 32'h77);
    chk("rr_stallreq", 32'(stallreq_o), 32'h0);
    tick; mem_ack = 1'b0;
    #3 chk("rr_req_after_ack", 32'(mem_req), 32'h0);
    tick;

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
